spi_byte_engine: RTL and testbench

// - Byte-oriented SPI master: programmable clock divider plus 8-bit full-duplex shifter, SPI mode 0, MSB first.
// - Sits between the SD-card command FSM and the card pins. Each byte slot is flagged by a one-cycle ByteDone strobe.
// - The FSM reads the received byte and updates OutputData for the next slot on that strobe.
// - Byte slots run continuously, so the FSM can also count idle slots as a timer.

---
 rtl/spi_byte_engine.sv | 114 +++++++++++
 tb/tb_spi_byte_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_engine.sv
// spi_byte_engine
//   Byte-oriented SPI master (mode 0, MSB first) with a programmable clock
//   divider. It runs back-to-back 16-tick byte slots. Each slot is marked by a
//   one-cycle ByteDone strobe. SPI_Enable and OutputData are sampled only at
//   slot boundaries, so a slot is either a full byte or fully idle.
//
// Ports
//   DataClock   in   system clock, posedge
//   Reset       in   synchronous, active-high
//   SPI_Enable  in   drive the bus during the next slot
//   OutputData  in   byte to send in the next slot (sampled at the boundary)
//   SPI_MISO    in   serial data from the card
//   SPI_MOSI    out  serial data to the card (idles high)
//   SPI_CLK     out  SPI clock (idles low)
//   InputData   out  byte received in the slot that just ended
//   ByteDone    out  one-cycle strobe at every slot boundary

module spi_byte_engine #(
  parameter int MASTER_FREQUENCY = 100000000,
  parameter int FREQUENCY        = 400000,
  parameter int BITS_NUMBER      = 8
) (
  input  logic       DataClock,
  input  logic       Reset,
  input  logic       SPI_Enable,
  input  logic [7:0] OutputData,
  input  logic       SPI_MISO,
  output logic       SPI_MOSI,
  output logic       SPI_CLK,
  output logic [7:0] InputData,
  output logic       ByteDone
);

  localparam int unsigned HALF = MASTER_FREQUENCY / (2 * FREQUENCY);
  localparam logic [BITS_NUMBER-1:0] DIV_LAST = BITS_NUMBER'(HALF - 1);

  logic [BITS_NUMBER-1:0] div_cnt_q,   div_cnt_d;
  logic [3:0]             tick_cnt_q,  tick_cnt_d;
  logic                   spi_clk_q,   spi_clk_d;
  logic                   mosi_q,      mosi_d;
  logic [7:0]             shift_out_q, shift_out_d;
  logic [7:0]             shift_in_q,  shift_in_d;
  logic [7:0]             in_data_q,   in_data_d;
  logic                   byte_done_q, byte_done_d;
  logic                   en_q,        en_d;
  logic                   tick;

  always_comb begin
    tick        = (div_cnt_q == DIV_LAST);
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    tick_cnt_d  = tick_cnt_q;
    spi_clk_d   = spi_clk_q;
    mosi_d      = mosi_q;
    shift_out_d = shift_out_q;
    shift_in_d  = shift_in_q;
    in_data_d   = in_data_q;
    byte_done_d = 1'b0;
    en_d        = en_q;

    if (tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      if (!tick_cnt_q[0]) begin
        // Rising tick: a disabled slot keeps the clock low and shifts in 1s,
        // so an idle slot reports 8'hFF.
        spi_clk_d  = en_q;
        shift_in_d = {shift_in_q[6:0], en_q ? SPI_MISO : 1'b1};
      end else if (tick_cnt_q != 4'd15) begin
        // Falling tick: present the next MSB-first bit while SPI_CLK is low.
        spi_clk_d   = 1'b0;
        shift_out_d = {shift_out_q[6:0], 1'b1};
        mosi_d      = en_q ? shift_out_q[6] : 1'b1;
      end else begin
        // Byte boundary: the 8th bit was already shifted in on the last
        // rising tick, so shift_in_q holds the complete byte.
        spi_clk_d   = 1'b0;
        in_data_d   = shift_in_q;
        shift_out_d = OutputData;
        en_d        = SPI_Enable;
        mosi_d      = SPI_Enable ? OutputData[7] : 1'b1;
        byte_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge DataClock) begin
    if (Reset) begin
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      spi_clk_q   <= 1'b0;
      mosi_q      <= 1'b1;
      shift_out_q <= '1;
      shift_in_q  <= '1;
      in_data_q   <= '1;
      byte_done_q <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      spi_clk_q   <= spi_clk_d;
      mosi_q      <= mosi_d;
      shift_out_q <= shift_out_d;
      shift_in_q  <= shift_in_d;
      in_data_q   <= in_data_d;
      byte_done_q <= byte_done_d;
      en_q        <= en_d;
    end
  end

  assign SPI_CLK   = spi_clk_q;
  assign SPI_MOSI  = mosi_q;
  assign InputData = in_data_q;
  assign ByteDone  = byte_done_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine
//   Scoreboard bench for spi_byte_engine with HALF=2 (32-cycle slots).
//   The driver issues one slot's stimulus per ByteDone and pushes the expected
//   slot result; the monitor pops and checks on every ByteDone.

module tb_spi_byte_engine;

  localparam int MF   = 8;
  localparam int FQ   = 2;
  localparam int SLOT = 16 * (MF / (2 * FQ));

  logic       DataClock;
  logic       Reset;
  logic       SPI_Enable;
  logic [7:0] OutputData;
  logic       SPI_MISO;
  logic       SPI_MOSI;
  logic       SPI_CLK;
  logic [7:0] InputData;
  logic       ByteDone;

  spi_byte_engine #(
    .MASTER_FREQUENCY(MF),
    .FREQUENCY       (FQ),
    .BITS_NUMBER     (8)
  ) dut (
    .DataClock (DataClock),
    .Reset     (Reset),
    .SPI_Enable(SPI_Enable),
    .OutputData(OutputData),
    .SPI_MISO  (SPI_MISO),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_CLK   (SPI_CLK),
    .InputData (InputData),
    .ByteDone  (ByteDone)
  );

  initial DataClock = 1'b0;
  always #5 DataClock = ~DataClock;

  typedef struct {
    bit         en;
    logic [7:0] out;
    bit         loop;
    logic [7:0] miso;
    bit         mid;
    logic [7:0] midv;
  } stim_t;

  typedef struct {
    bit         en;
    logic [7:0] tx;
    logic [7:0] rx;
    bit         loop;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Slave-side model: MISO is either a fixed byte shifted on SPI_CLK falls,
  // or a loopback of MOSI.
  bit         cur_loop  = 1'b0;
  logic [7:0] miso_sr   = 8'hFF;
  bit         pend_loop = 1'b0;
  logic [7:0] pend_miso = 8'hFF;
  bit         pend_mid  = 1'b0;
  logic [7:0] pend_midv = 8'h00;
  bit         clk_prev  = 1'b0;

  assign SPI_MISO = cur_loop ? SPI_MOSI : miso_sr[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic       rst_s;
  int         gap = 0;
  int         rises = 0;
  logic [7:0] cap = 8'h00;
  bit         mclk_prev = 1'b0;
  bit         bd_prev = 1'b0;
  bit         idle_bad = 1'b0;

  always @(posedge DataClock) rst_s <= Reset;

  always @(negedge DataClock) begin
    exp_t e;
    if (rst_s) begin
      chk("rst_spi_clk",   int'(SPI_CLK),   0);
      chk("rst_mosi",      int'(SPI_MOSI),  1);
      chk("rst_bytedone",  int'(ByteDone),  0);
      chk("rst_inputdata", int'(InputData), 'hFF);
      gap = 0; rises = 0; cap = 8'h00; idle_bad = 1'b0;
      bd_prev = 1'b0; mclk_prev = 1'b0;
    end else begin
      gap++;
      if (SPI_CLK && !mclk_prev) begin
        rises++;
        cap = {cap[6:0], SPI_MOSI};
      end
      if (!ByteDone && SPI_MOSI !== 1'b1) idle_bad = 1'b1;
      if (gap == SLOT) chk("bytedone_on_time", int'(ByteDone), 1);
      if (ByteDone) begin
        chk("bytedone_width", int'(bd_prev), 0);
        chk("slot_length", gap, SLOT);
        chk("sb_has_entry", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("clk_pulses", rises, e.en ? 8 : 0);
          if (e.en) chk("mosi_byte", int'(cap), int'(e.tx));
          else      chk("idle_mosi_high", int'(idle_bad), 0);
          chk("input_data", int'(InputData), int'(e.rx));
        end
        gap = 0; rises = 0; cap = 8'h00; idle_bad = 1'b0;
      end
      bd_prev   = ByteDone;
      mclk_prev = SPI_CLK;
    end
  end

  // ---------------- driver ----------------
  function automatic stim_t rnd_stim(input bit force_en);
    stim_t s;
    s.en   = force_en ? 1'b1 : ($urandom_range(0, 3) != 0);
    s.out  = 8'($urandom);
    s.loop = force_en ? 1'b0 : 1'($urandom_range(0, 1));
    s.miso = 8'($urandom);
    s.mid  = force_en ? 1'b0 : 1'($urandom_range(0, 1));
    s.midv = 8'($urandom);
    return s;
  endfunction

  task automatic push_idle_pair();
    exp_t e;
    e.en = 1'b0; e.tx = 8'hFF; e.rx = 8'hFF; e.loop = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
  endtask

  // Advance to the next ByteDone (bounded); mid-slot, optionally rewrite the
  // pending OutputData while the current byte is in flight.
  task automatic wait_bd();
    for (int c = 1; c <= 2 * SLOT; c++) begin
      @(negedge DataClock);
      if (ByteDone) break;
      if (clk_prev && !SPI_CLK) miso_sr = {miso_sr[6:0], 1'b1};
      clk_prev = SPI_CLK;
      if (c == 10 && pend_mid && sb.size() != 0) begin
        OutputData = pend_midv;
        sb[sb.size()-1].tx = pend_midv;
        if (sb[sb.size()-1].en && sb[sb.size()-1].loop) sb[sb.size()-1].rx = pend_midv;
      end
    end
  endtask

  // Called at a ByteDone: the slot now starting uses the previously pending
  // slave behaviour; the new stimulus is latched at the following boundary.
  task automatic issue(input stim_t s);
    exp_t e;
    cur_loop   = pend_loop;
    miso_sr    = pend_miso;
    clk_prev   = 1'b0;
    SPI_Enable = s.en;
    OutputData = s.out;
    pend_loop  = s.loop;
    pend_miso  = s.miso;
    pend_mid   = s.mid;
    pend_midv  = s.midv;
    e.en   = s.en;
    e.tx   = s.out;
    e.rx   = !s.en ? 8'hFF : (s.loop ? s.out : s.miso);
    e.loop = s.loop;
    sb.push_back(e);
  endtask

  task automatic slave_idle();
    cur_loop = 1'b0; miso_sr = 8'hFF; pend_loop = 1'b0;
    pend_miso = 8'hFF; pend_mid = 1'b0; clk_prev = 1'b0;
  endtask

  stim_t dir[8];

  initial begin
    dir[0] = '{1'b1, 8'h40, 1'b0, 8'h5A, 1'b0, 8'h00};
    dir[1] = '{1'b1, 8'h95, 1'b1, 8'h00, 1'b0, 8'h00};
    dir[2] = '{1'b1, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00};
    dir[3] = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00};
    dir[4] = '{1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00};
    dir[5] = '{1'b0, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00};
    dir[6] = '{1'b1, 8'hA5, 1'b0, 8'hE7, 1'b0, 8'h00};
    dir[7] = '{1'b1, 8'h11, 1'b1, 8'h00, 1'b1, 8'h3C};

    Reset = 1'b1; SPI_Enable = 1'b0; OutputData = 8'h00;
    slave_idle();
    repeat (3) @(negedge DataClock);
    Reset = 1'b0;
    push_idle_pair();

    for (int i = 0; i < 30; i++) begin
      wait_bd();
      if (i < 8) issue(dir[i]);
      else       issue(rnd_stim(i >= 28));
    end

    // Abandon an enabled slot while SPI_CLK is high.
    for (int c = 0; c < 20; c++) begin
      @(negedge DataClock);
      if (c >= 9 && SPI_CLK) break;
    end
    Reset = 1'b1;
    SPI_Enable = 1'b0;
    sb.delete();
    slave_idle();
    repeat (3) @(negedge DataClock);
    Reset = 1'b0;
    push_idle_pair();

    for (int i = 0; i < 3; i++) begin
      wait_bd();
      issue(rnd_stim(1'b0));
    end
    wait_bd();
    repeat (2) @(negedge DataClock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
